// File: rtl/fb_access_ctrl.sv
// Frame buffer access controller: arbitrates the single write port between a
// full-screen clear engine and a pixel draw client, and sequences raster reads.
module fb_access_ctrl #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_color,
  output logic              clear_busy,
  output logic              clear_done,
  input  logic              draw_valid,
  input  logic [8:0]        draw_x,
  input  logic [7:0]        draw_y,
  input  logic [DATA_W-1:0] draw_data,
  output logic              draw_ready,
  input  logic              disp_sof,
  input  logic              disp_en,
  output logic              disp_valid,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_write_addr,
  output logic [DATA_W-1:0] fb_write_data,
  output logic [ADDR_W-1:0] fb_read_addr,
  output logic              state_dbg
);

  // Handshake: a draw transfers on a rising edge where draw_valid && draw_ready;
  // the client holds x/y/data stable while draw_valid is high and not yet accepted.

  localparam logic [ADDR_W-1:0] TOTAL = ADDR_W'(WIDTH * HEIGHT);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [8:0]        X_LIM = 9'(WIDTH);
  localparam logic [7:0]        Y_LIM = 8'(HEIGHT);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   clear_cnt;
  logic [DATA_W-1:0]   color_q;
  logic                disp_valid_q;
  logic                draw_accept;
  logic                draw_in_range;
  logic                clear_issue;
  logic [ADDR_W-1:0]   draw_addr;

  assign draw_ready    = (state == IDLE) && !rst;
  assign draw_accept   = draw_valid && draw_ready;
  assign draw_in_range = (draw_x < X_LIM) && (draw_y < Y_LIM);
  // y*320 + x as two shifts and adds
  assign draw_addr     = {1'b0, draw_y, 8'b0} + {3'b0, draw_y, 6'b0} + {8'b0, draw_x};
  // Counter runs one past LAST so CLEAR covers the cycle the final write is presented.
  assign clear_issue   = (state == CLEAR) && (clear_cnt != TOTAL);
  assign clear_busy    = (state == CLEAR);
  assign disp_valid    = disp_valid_q && !rst;
  assign state_dbg     = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (clear_start) state_next = CLEAR;
      CLEAR:   if (clear_cnt == TOTAL) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clear_cnt <= '0;
      color_q   <= '0;
    end else if (state == IDLE && clear_start) begin
      clear_cnt <= '0;
      color_q   <= clear_color;
    end else if (clear_issue) begin
      clear_cnt <= clear_cnt + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fb_we         <= 1'b0;
      fb_write_addr <= '0;
      fb_write_data <= '0;
      clear_done    <= 1'b0;
    end else begin
      fb_we      <= 1'b0;
      clear_done <= 1'b0;
      if (clear_issue) begin
        fb_we         <= 1'b1;
        fb_write_addr <= clear_cnt;
        fb_write_data <= color_q;
        clear_done    <= (clear_cnt == LAST);
      end else if (draw_accept && draw_in_range) begin
        fb_we         <= 1'b1;
        fb_write_addr <= draw_addr;
        fb_write_data <= draw_data;
      end
    end
  end

  // Raster read sequencer, independent of the write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      fb_read_addr <= '0;
      disp_valid_q <= 1'b0;
    end else begin
      disp_valid_q <= disp_en;
      if (disp_sof)
        fb_read_addr <= '0;
      else if (disp_en)
        fb_read_addr <= (fb_read_addr == LAST) ? '0 : fb_read_addr + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_fb_access_ctrl.sv
// Self-checking bench for fb_access_ctrl: write-port scoreboard with cycle
// stamps, clear/draw arbitration, raster read sequencing and reset abort.
module tb_fb_access_ctrl;

  localparam int W     = 57;  // {cycle[31:0], addr[16:0], data[7:0]}
  localparam int TOTAL = 76800;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_start;
  logic [7:0]  clear_color;
  logic        clear_busy;
  logic        clear_done;
  logic        draw_valid;
  logic [8:0]  draw_x;
  logic [7:0]  draw_y;
  logic [7:0]  draw_data;
  logic        draw_ready;
  logic        disp_sof;
  logic        disp_en;
  logic        disp_valid;
  logic        fb_we;
  logic [16:0] fb_write_addr;
  logic [7:0]  fb_write_data;
  logic [16:0] fb_read_addr;
  logic        state_dbg;

  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;

  fb_access_ctrl dut (
    .clk(clk), .rst(rst),
    .clear_start(clear_start), .clear_color(clear_color),
    .clear_busy(clear_busy), .clear_done(clear_done),
    .draw_valid(draw_valid), .draw_x(draw_x), .draw_y(draw_y),
    .draw_data(draw_data), .draw_ready(draw_ready),
    .disp_sof(disp_sof), .disp_en(disp_en), .disp_valid(disp_valid),
    .fb_we(fb_we), .fb_write_addr(fb_write_addr), .fb_write_data(fb_write_data),
    .fb_read_addr(fb_read_addr), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] pack(input int c, input int addr, input logic [7:0] d);
    return {32'(c), 17'(addr), d};
  endfunction

  // scoreboard: every presented write must match the head of exp_q
  always @(negedge clk) begin
    if (fb_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("wr_extra", {31'b0, fb_we}, 32'd0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("wr_addr", {15'b0, fb_write_addr}, {15'b0, e[24:8]});
        check("wr_data", {24'b0, fb_write_data}, {24'b0, e[7:0]});
        check("wr_cyc", cyc, e[56:25]);
      end
    end
    if (clear_done === 1'b1) begin
      done_cnt++;
      check("done_addr", {15'b0, fb_write_addr}, 32'(TOTAL - 1));
    end
    if (clear_busy === 1'b1 && draw_ready !== 1'b0)
      check("ready_in_clear", {31'b0, draw_ready}, 32'd0);
  end

  // driver tasks
  task automatic do_draw(input int x, input int y, input logic [7:0] d);
    draw_valid = 1'b1;
    draw_x     = 9'(x);
    draw_y     = 8'(y);
    draw_data  = d;
    check("draw_ready", {31'b0, draw_ready}, 32'd1);
    if (x < 320 && y < 240) exp_q.push_back(pack(cyc + 1, y * 320 + x, d));
    @(posedge clk); #1;
    draw_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    check(tag, exp_q.size(), 32'd0);
  endtask

  initial begin
    int c;
    int done_before;
    int exp_ra;
    int n;
    int en;

    rst = 1'b1; clear_start = 1'b0; clear_color = '0;
    draw_valid = 1'b0; draw_x = '0; draw_y = '0; draw_data = '0;
    disp_sof = 1'b0; disp_en = 1'b0;

    // reset state
    repeat (3) @(posedge clk); #1;
    check("rst_ready", {31'b0, draw_ready}, 32'd0);
    check("rst_we", {31'b0, fb_we}, 32'd0);
    check("rst_waddr", {15'b0, fb_write_addr}, 32'd0);
    check("rst_wdata", {24'b0, fb_write_data}, 32'd0);
    check("rst_raddr", {15'b0, fb_read_addr}, 32'd0);
    check("rst_busy", {31'b0, clear_busy}, 32'd0);
    check("rst_done", {31'b0, clear_done}, 32'd0);
    check("rst_dvalid", {31'b0, disp_valid}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ready", {31'b0, draw_ready}, 32'd1);
      check("idle_we", {31'b0, fb_we}, 32'd0);
      check("idle_busy", {31'b0, clear_busy}, 32'd0);
    end

    // directed and random draws, back-to-back
    @(posedge clk); #1;
    do_draw(0, 0, 8'h11);
    do_draw(319, 0, 8'h22);
    do_draw(0, 1, 8'h33);
    do_draw(319, 239, 8'h44);
    do_draw(320, 5, 8'h55);
    do_draw(5, 240, 8'h66);
    for (int i = 0; i < 12; i++)
      do_draw($urandom_range(0, 330), $urandom_range(0, 250), 8'($urandom_range(0, 255)));
    drain("draw_drain");

    // full clear with concurrent raster reads
    @(posedge clk); #1;
    fork
      begin
        c = cyc;
        clear_start = 1'b1;
        clear_color = 8'hA5;
        for (int k = 0; k < TOTAL; k++) exp_q.push_back(pack(c + 2 + k, k, 8'hA5));
        done_before = done_cnt;
        @(posedge clk); #1;
        clear_start = 1'b0;
        repeat (500) @(posedge clk); #1;
        clear_start = 1'b1;
        clear_color = 8'h00;
        @(posedge clk); #1;
        clear_start = 1'b0;
        n = 0;
        while (clear_done !== 1'b1 && n < 80000) begin @(negedge clk); n++; end
        check("done_seen", {31'b0, clear_done}, 32'd1);
        check("done_cyc", cyc, c + TOTAL + 1);
        check("done_busy", {31'b0, clear_busy}, 32'd1);
        @(negedge clk);
        check("post_ready", {31'b0, draw_ready}, 32'd1);
        check("post_busy", {31'b0, clear_busy}, 32'd0);
        check("done_once", done_cnt - done_before, 32'd1);
      end
      begin
        disp_sof = 1'b1;
        @(posedge clk); #1;
        check("rd_sof", {15'b0, fb_read_addr}, 32'd0);
        check("dv_idle", {31'b0, disp_valid}, 32'd0);
        disp_sof = 1'b0;
        exp_ra = 0;
        for (int i = 0; i < 20; i++) begin
          en = $urandom_range(0, 1);
          disp_en = en[0];
          @(posedge clk); #1;
          if (en != 0) exp_ra++;
          check("rd_rand", {15'b0, fb_read_addr}, exp_ra);
          check("dv_lag", {31'b0, disp_valid}, en);
        end
        disp_sof = 1'b1; disp_en = 1'b0;
        @(posedge clk); #1;
        check("rd_rewind", {15'b0, fb_read_addr}, 32'd0);
        disp_sof = 1'b0; disp_en = 1'b1;
        exp_ra = 0;
        for (int i = 0; i < TOTAL + 1; i++) begin
          @(posedge clk); #1;
          exp_ra = (exp_ra == TOTAL - 1) ? 0 : exp_ra + 1;
          check("rd_addr", {15'b0, fb_read_addr}, exp_ra);
          check("dv_full", {31'b0, disp_valid}, 32'd1);
        end
        disp_sof = 1'b1; disp_en = 1'b1;
        @(posedge clk); #1;
        check("rd_sof_en", {15'b0, fb_read_addr}, 32'd0);
        disp_sof = 1'b0; disp_en = 1'b0;
        @(posedge clk); #1;
        check("dv_off", {31'b0, disp_valid}, 32'd0);
      end
    join
    drain("clear_drain");

    // same-cycle draw and clear_start, then reset at clear address 1000
    @(posedge clk); #1;
    c = cyc;
    done_before = done_cnt;
    draw_valid = 1'b1; draw_x = 9'd2; draw_y = 8'd0; draw_data = 8'h7E;
    clear_start = 1'b1; clear_color = 8'h3C;
    exp_q.push_back(pack(c + 1, 2, 8'h7E));
    for (int k = 0; k <= 1000; k++) exp_q.push_back(pack(c + 2 + k, k, 8'h3C));
    @(posedge clk); #1;
    draw_valid = 1'b0; clear_start = 1'b0;
    repeat (1001) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_state", {31'b0, state_dbg}, 32'd0);
    check("abort_ready", {31'b0, draw_ready}, 32'd1);
    check("abort_busy", {31'b0, clear_busy}, 32'd0);
    check("abort_we", {31'b0, fb_we}, 32'd0);
    repeat (20) @(negedge clk);
    check("abort_q", exp_q.size(), 32'd0);
    check("abort_nodone", done_cnt - done_before, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fb_access_ctrl.md
# fb_access_ctrl

Access controller for the 320x240, 8-bit frame buffer. It drives the buffer's write port and read address, and owns the write port exclusively. Writes come from either a clear engine that fills the whole buffer with one colour, or a pixel draw client using a valid/ready handshake with (x, y) coordinates. A raster read-address sequencer feeds the display path and flags when read data is valid. It sits between the drawing logic, the display timing logic and the frame buffer RAM, whose read has one cycle of latency.

## Interface
- WIDTH, 320, pixels per line
- HEIGHT, 240, lines per frame
- ADDR_W, 17, frame buffer address width
- DATA_W, 8, pixel width
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- clear_start  in  1  request a full-buffer fill (pulse or level)
- clear_color  in  DATA_W  fill value, sampled when clear_start is accepted
- clear_busy  out  1  high while the clear engine owns the write port
- clear_done  out  1  one-cycle pulse after the final clear write
- draw_valid  in  1  draw request valid
- draw_x  in  9  pixel column
- draw_y  in  8  pixel row
- draw_data  in  DATA_W  pixel value
- draw_ready  out  1  draw request can be accepted
- disp_sof  in  1  start of frame; rewinds the read address
- disp_en  in  1  display consumes one pixel this cycle
- disp_valid  out  1  fb read_data holds the requested pixel
- fb_we  out  1  frame buffer write enable
- fb_write_addr  out  ADDR_W  frame buffer write address
- fb_write_data  out  DATA_W  frame buffer write data
- fb_read_addr  out  ADDR_W  frame buffer read address

## Operation
- States: IDLE and CLEAR.
- IDLE → CLEAR when clear_start=1.
  - Latch clear_color.
  - Set clear counter to 0.
- CLEAR:
  - Each cycle, register one write: fb_write_addr = counter, fb_write_data = latched colour.
  - Increment the counter.
  - After issuing address WIDTH*HEIGHT-1 (76799), return to IDLE and pulse clear_done in the cycle that last write is presented.
- clear_start while in CLEAR is ignored; the fill is not restarted.
- clear_busy = (state==CLEAR).
- draw_ready = (state==IDLE) && !rst; it is 0 for the whole fill.
- Draw accept = draw_valid && draw_ready.
  - Address = y*320 + x, computed as (y<<8)+(y<<6)+x at 17 bits. No multiplier.
  - Valid request: registered write, fb_we=1 in the next cycle.
- A draw accepted with x≥WIDTH or y≥HEIGHT is consumed (handshake completes) but produces no write (fb_we=0).
- Same-cycle clear_start and draw accept in IDLE:
  - The draw is accepted and writes at t+1.
  - The clear enters CLEAR at t+1, with its first write (address 0) at t+2.
- Read sequencer, fb_read_addr register:
  - disp_sof=1: next value 0. disp_sof has priority over disp_en.
  - Else disp_en=1: next value +1, wrapping 76799 → 0.
  - Otherwise hold.
- disp_valid = disp_en registered one cycle, forced 0 when rst=1.
- The read sequencer runs independently of the write port; clear and draw never stall display reads.
- Reset values: state IDLE, counter 0, fb_we 0, fb_write_addr 0, fb_write_data 0, fb_read_addr 0, clear_busy 0, clear_done 0, disp_valid 0, draw_ready 0 while rst is high.
- Reset during CLEAR aborts the fill:
  - No further writes after the reset cycle.
  - No clear_done pulse.

## Timing
- Draw: accept at edge t → fb_we/addr/data valid during cycle t+1. Throughput is one draw per cycle.
- Clear:
  - clear_start at t → writes during cycles t+2 … t+76801.
  - clear_done in cycle t+76801.
  - draw_ready=1 again in cycle t+76802.
- Read: disp_en in cycle t with fb_read_addr=A → RAM samples A at end of t → read_data and disp_valid=1 in cycle t+1.
- fb_we deasserts in the cycle after the last accepted draw unless a new draw is accepted.

## Test plan
- Reset, then idle → all outputs 0 except draw_ready=1. No fb_we for 10 cycles.
- Draws (0,0,0x11), (319,0,0x22), (0,1,0x33), (319,239,0x44) back-to-back:
  - Writes to addresses 0, 319, 320, 76799 with matching data, one per cycle, each one cycle after acceptance.
  - Draw (320,5) and draw (5,240) → accepted, no fb_we.
- clear_start with clear_color=0xA5:
  - 76800 consecutive writes, addresses 0..76799, all data 0xA5.
  - clear_done exactly once, on address 76799.
  - draw_ready=0 throughout the fill.
  - A second clear_start mid-fill has no effect.
- Same-cycle draw (2,0,0x7E) and clear_start → write addr 2 = 0x7E at t+1, then clear writes starting at addr 0 from t+2.
- Display:
  - disp_sof, then 76801 disp_en cycles → fb_read_addr 0,1,…,76799,0.
  - disp_valid lags disp_en by exactly one cycle.
  - disp_sof and disp_en in the same cycle → fb_read_addr=0 next cycle.
- Assert rst at clear address 1000 → no writes after the reset cycle, no clear_done, state IDLE, draw_ready=1 the cycle after rst falls.
